// File: rtl/gba_pkg.sv
// Shared types and constants for the GBA save upload path (SDRAM -> HPS ioctl).
package gba_pkg;

  typedef enum logic [2:0] {
    UPL_IDLE     = 3'd0,
    UPL_FETCH    = 3'd1,
    UPL_WAIT_ACK = 3'd2,
    UPL_READY    = 3'd3,
    UPL_DONE     = 3'd4
  } upl_state_t;

  localparam logic [21:0] SAVE_BASE_DEF = 22'h3C0000;

  localparam int unsigned SAVE_SRAM_BYTES     = 32768;
  localparam int unsigned SAVE_FLASH64_BYTES  = 65536;
  localparam int unsigned SAVE_FLASH128_BYTES = 131072;
  localparam int unsigned SAVE_EEPROM_BYTES   = 8192;

endpackage

// File: rtl/gba_save_uploader.sv
// Streams backup-save bytes from SDRAM to the HPS ioctl upload path, one byte per
// ioctl_rd strobe, holding ioctl_wait high until each byte is valid.
module gba_save_uploader
  import gba_pkg::*;
#(
  parameter int          ADDR_W    = 22,
  parameter logic [ADDR_W-1:0] SAVE_BASE = ADDR_W'(SAVE_BASE_DEF),
  parameter int          SIZE_W    = 18,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  input  logic [SIZE_W-1:0] save_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  upl_state_t        state;
  logic              upload_q;
  logic [SIZE_W-1:0] idx;
  logic [SIZE_W-1:0] idx_next;
  logic [SIZE_W-1:0] size_q;
  logic [7:0]        tmo;

  assign idx_next = idx + 1'b1;
  assign busy     = (state == UPL_FETCH) || (state == UPL_WAIT_ACK) || (state == UPL_READY);

  // upload_q tracks the input even during reset so a window held open across
  // reset is not mistaken for a fresh upload start.
  always_ff @(posedge clk_sys) begin
    upload_q <= ioctl_upload;
    if (reset) begin
      state      <= UPL_IDLE;
      idx        <= '0;
      size_q     <= '0;
      tmo        <= '0;
      ioctl_din  <= 8'hFF;
      ioctl_wait <= 1'b0;
      mem_addr   <= SAVE_BASE;
      mem_rd     <= 1'b0;
      err        <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      if (state != UPL_IDLE && !ioctl_upload) begin
        state      <= UPL_IDLE;
        ioctl_wait <= 1'b0;
      end else begin
        case (state)
          UPL_IDLE: begin
            if (ioctl_upload && !upload_q) begin
              size_q <= save_size;
              idx    <= '0;
              err    <= 1'b0;
              if (save_size == '0) begin
                state      <= UPL_DONE;
                ioctl_din  <= 8'hFF;
                ioctl_wait <= 1'b0;
              end else begin
                state      <= UPL_FETCH;
                ioctl_wait <= 1'b1;
              end
            end
          end
          UPL_FETCH: begin
            mem_rd   <= 1'b1;
            mem_addr <= SAVE_BASE + ADDR_W'(idx);
            tmo      <= '0;
            state    <= UPL_WAIT_ACK;
          end
          UPL_WAIT_ACK: begin
            if (mem_ack) begin
              ioctl_din  <= mem_dout;
              ioctl_wait <= 1'b0;
              state      <= UPL_READY;
            end else if (tmo == TMO_LAST) begin
              ioctl_din  <= 8'hFF;
              err        <= 1'b1;
              ioctl_wait <= 1'b0;
              state      <= UPL_READY;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          UPL_READY: begin
            if (ioctl_rd) begin
              if (idx_next == size_q) begin
                state     <= UPL_DONE;
                ioctl_din <= 8'hFF;
              end else begin
                idx        <= idx_next;
                ioctl_wait <= 1'b1;
                state      <= UPL_FETCH;
              end
            end
          end
          UPL_DONE: begin
            ioctl_din  <= 8'hFF;
            ioctl_wait <= 1'b0;
          end
          default: state <= UPL_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gba_save_uploader.sv
// Directed self-checking bench for gba_save_uploader; a second instance with a
// base near the top of SDRAM runs in lockstep to observe address wrap.
module tb_gba_save_uploader;
  import gba_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [17:0] save_size = '0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_dout = '0;

  logic [7:0]  ioctl_din, ioctl_din_w;
  logic        ioctl_wait, ioctl_wait_w;
  logic [21:0] mem_addr, mem_addr_w;
  logic        mem_rd, mem_rd_w;
  logic        busy, busy_w;
  logic        err, err_w;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  gba_save_uploader dut (
    .clk_sys(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .save_size(save_size),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_dout(mem_dout),
    .busy(busy), .err(err)
  );

  gba_save_uploader #(.SAVE_BASE(22'h3FFFFE)) dut_w (
    .clk_sys(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din_w), .ioctl_wait(ioctl_wait_w), .save_size(save_size),
    .mem_addr(mem_addr_w), .mem_rd(mem_rd_w), .mem_ack(mem_ack), .mem_dout(mem_dout),
    .busy(busy_w), .err(err_w)
  );

  task automatic start_upload(input logic [17:0] size);
    save_size    = size;
    ioctl_upload = 1'b1;
    @(negedge clk);
  endtask

  task automatic drop_upload();
    ioctl_upload = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_rd();
    ioctl_rd = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
  endtask

  task automatic count_rd(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mem_rd) seen++;
    end
  endtask

  // Waits (bounded) for mem_rd, optionally acks 'delay' cycles later, then
  // counts cycles from mem_rd until ioctl_wait falls. lat=50 means no mem_rd.
  task automatic serve_read(input int delay, input logic [7:0] data, input bit give_ack,
                            output logic [21:0] a, output logic [21:0] aw,
                            output int lat, output int resp, output bit wait_hi);
    lat = 0; resp = 0; wait_hi = 1'b1; a = '1; aw = '1;
    while (!mem_rd && lat < 50) begin
      @(negedge clk);
      lat++;
      if (!ioctl_wait) wait_hi = 1'b0;
    end
    if (mem_rd) begin
      a  = mem_addr;
      aw = mem_addr_w;
      while (resp < 400) begin
        if (give_ack && resp == delay) begin
          mem_ack  = 1'b1;
          mem_dout = data;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        resp++;
        if (!ioctl_wait) break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ioctl_din !== 8'hFF) $display("FAIL reset_din got=%h exp=ff", ioctl_din); else passes++;
    checks++; if (ioctl_wait !== 1'b0) $display("FAIL reset_wait got=%b exp=0", ioctl_wait); else passes++;
    checks++; if (mem_addr !== 22'h3C0000) $display("FAIL reset_addr got=%h exp=3c0000", mem_addr); else passes++;
    checks++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); else passes++;
    checks++; if ({busy, err} !== 2'b00) $display("FAIL reset_busy_err got=%b exp=00", {busy, err}); else passes++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] data [4];
    logic [21:0] a, aw;
    int lat, resp, seen;
    bit wh;
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33; data[3] = 8'h44;
    start_upload(18'd4);
    checks++; if ({ioctl_wait, busy} !== 2'b11) $display("FAIL t1_start got=%b exp=11", {ioctl_wait, busy}); else passes++;
    for (int k = 0; k < 4; k++) begin
      serve_read(3, data[k], 1'b1, a, aw, lat, resp, wh);
      checks++; if (lat !== 1) $display("FAIL t1_latency byte=%0d got=%0d exp=1", k, lat); else passes++;
      checks++; if (a !== 22'h3C0000 + 22'(k)) $display("FAIL t1_addr byte=%0d got=%h exp=%h", k, a, 22'h3C0000 + 22'(k)); else passes++;
      checks++; if (!wh || resp !== 4) $display("FAIL t1_wait_fetch byte=%0d got=%0d/%b exp=4/1", k, resp, wh); else passes++;
      checks++; if (ioctl_din !== data[k]) $display("FAIL t1_din byte=%0d got=%h exp=%h", k, ioctl_din, data[k]); else passes++;
      pulse_rd();
      if (k < 3) begin
        checks++; if (ioctl_wait !== 1'b1) $display("FAIL t1_wait_rise byte=%0d got=%b exp=1", k, ioctl_wait); else passes++;
      end
    end
    checks++; if (dut.state !== UPL_DONE) $display("FAIL t1_done_state got=%0d exp=%0d", dut.state, UPL_DONE); else passes++;
    checks++; if ({busy, err, ioctl_wait} !== 3'b000) $display("FAIL t1_done_flags got=%b exp=000", {busy, err, ioctl_wait}); else passes++;
    checks++; if (ioctl_din !== 8'hFF) $display("FAIL t1_done_din got=%h exp=ff", ioctl_din); else passes++;
    pulse_rd();
    count_rd(5, seen);
    checks++; if (seen !== 0) $display("FAIL t1_done_rd_ignored got=%0d exp=0", seen); else passes++;
    drop_upload();
  endtask

  task automatic test_zero_size();
    int seen;
    start_upload(18'd0);
    checks++; if (dut.state !== UPL_DONE) $display("FAIL t2_state got=%0d exp=%0d", dut.state, UPL_DONE); else passes++;
    checks++; if ({ioctl_din, ioctl_wait, busy} !== {8'hFF, 2'b00}) $display("FAIL t2_outputs got=%h/%b/%b exp=ff/0/0", ioctl_din, ioctl_wait, busy); else passes++;
    count_rd(6, seen);
    checks++; if (seen !== 0) $display("FAIL t2_no_mem_rd got=%0d exp=0", seen); else passes++;
    drop_upload();
  endtask

  task automatic test_timeout();
    logic [21:0] a, aw;
    int lat, resp;
    bit wh;
    start_upload(18'd2);
    serve_read(0, 8'h00, 1'b0, a, aw, lat, resp, wh);
    checks++; if (resp !== 255) $display("FAIL t3_timeout_cycles got=%0d exp=255", resp); else passes++;
    checks++; if ({ioctl_din, err} !== {8'hFF, 1'b1}) $display("FAIL t3_timeout_out got=%h/%b exp=ff/1", ioctl_din, err); else passes++;
    pulse_rd();
    serve_read(3, 8'h5A, 1'b1, a, aw, lat, resp, wh);
    checks++; if (a !== 22'h3C0001) $display("FAIL t3_addr2 got=%h exp=3c0001", a); else passes++;
    checks++; if ({ioctl_din, err} !== {8'h5A, 1'b1}) $display("FAIL t3_byte2 got=%h/%b exp=5a/1", ioctl_din, err); else passes++;
    pulse_rd();
    drop_upload();
    checks++; if (err !== 1'b1) $display("FAIL t3_err_sticky got=%b exp=1", err); else passes++;
  endtask

  task automatic test_abort();
    logic [21:0] a, aw;
    logic [7:0] din_before;
    int lat, resp, n;
    bit wh;
    start_upload(18'd3);
    checks++; if (err !== 1'b0) $display("FAIL t4_err_cleared got=%b exp=0", err); else passes++;
    n = 0;
    while (!mem_rd && n < 20) begin @(negedge clk); n++; end
    checks++; if (mem_rd !== 1'b1) $display("FAIL t4_mem_rd got=%b exp=1", mem_rd); else passes++;
    @(negedge clk);
    ioctl_upload = 1'b0;
    @(negedge clk);
    checks++; if (dut.state !== UPL_IDLE || ioctl_wait !== 1'b0) $display("FAIL t4_abort got=%0d/%b exp=%0d/0", dut.state, ioctl_wait, UPL_IDLE); else passes++;
    din_before = ioctl_din;
    mem_ack = 1'b1; mem_dout = 8'hC3;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (ioctl_din !== din_before) $display("FAIL t4_late_ack got=%h exp=%h", ioctl_din, din_before); else passes++;
    start_upload(18'd1);
    serve_read(2, 8'h77, 1'b1, a, aw, lat, resp, wh);
    checks++; if (a !== 22'h3C0000) $display("FAIL t4_restart_addr got=%h exp=3c0000", a); else passes++;
    checks++; if ({ioctl_din, err} !== {8'h77, 1'b0}) $display("FAIL t4_restart_byte got=%h/%b exp=77/0", ioctl_din, err); else passes++;
    pulse_rd();
    drop_upload();
  endtask

  task automatic test_wrap();
    logic [21:0] exp_w [4];
    logic [21:0] a, aw;
    int lat, resp;
    bit wh;
    exp_w[0] = 22'h3FFFFE; exp_w[1] = 22'h3FFFFF; exp_w[2] = 22'h000000; exp_w[3] = 22'h000001;
    start_upload(18'd4);
    for (int k = 0; k < 4; k++) begin
      serve_read(1, 8'hA0 + 8'(k), 1'b1, a, aw, lat, resp, wh);
      checks++; if (aw !== exp_w[k]) $display("FAIL t5_wrap_addr byte=%0d got=%h exp=%h", k, aw, exp_w[k]); else passes++;
      pulse_rd();
    end
    checks++; if (busy_w !== 1'b0) $display("FAIL t5_done got=%b exp=0", busy_w); else passes++;
    drop_upload();
  endtask

  task automatic test_reset_ready();
    logic [21:0] a, aw;
    int lat, resp, seen;
    bit wh;
    start_upload(18'd3);
    serve_read(3, 8'h99, 1'b1, a, aw, lat, resp, wh);
    checks++; if (dut.state !== UPL_READY) $display("FAIL t6_ready got=%0d exp=%0d", dut.state, UPL_READY); else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({ioctl_din, ioctl_wait, mem_rd, busy, err} !== {8'hFF, 4'b0000}) $display("FAIL t6_reset_outs got=%h/%b%b%b%b exp=ff/0000", ioctl_din, ioctl_wait, mem_rd, busy, err); else passes++;
    checks++; if (mem_addr !== 22'h3C0000) $display("FAIL t6_reset_addr got=%h exp=3c0000", mem_addr); else passes++;
    reset = 1'b0;
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_rd();
      if (mem_rd) seen++;
      @(negedge clk);
      if (mem_rd) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL t6_no_mem_rd got=%0d exp=0", seen); else passes++;
    drop_upload();
    start_upload(18'd1);
    serve_read(1, 8'h42, 1'b1, a, aw, lat, resp, wh);
    checks++; if (a !== 22'h3C0000 || ioctl_din !== 8'h42) $display("FAIL t6_restart got=%h/%h exp=3c0000/42", a, ioctl_din); else passes++;
    pulse_rd();
    drop_upload();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_size();
    test_timeout();
    test_abort();
    test_wrap();
    test_reset_ready();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
